// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared timer offsets, CTRL fields, FSM states and byte-lane helpers for dm_responder
package dm_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tmr_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  // Byte, aligned half and full word are the only lane patterns the core emits.
  function automatic logic be_legal(input logic [3:0] be);
    logic r;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_timer.sv
// rtl/dm_timer.sv - memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and auto-reload irq
module dm_timer
  import dm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byteen_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  tmr_state_e  state_q, state_d;
  logic        irq_q, irq_d;
  logic        en, auto_rl;

  assign en      = ctrl_q[CTRL_EN];
  assign auto_rl = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    irq_d    = irq_q;
    case (state_q)
      IDLE: if (en) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = INT;
          irq_d   = ctrl_q[CTRL_IM];
        end
      end
      INT: begin
        state_d = IDLE;
        if (auto_rl) irq_d = 1'b0;
        else         ctrl_d[CTRL_EN] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Bus writes land after the FSM so they override its EN update.
    if (we_i && off_i == OFF_CTRL) begin
      if (byteen_i[0]) ctrl_d = wdata_i[3:0];
      irq_d = 1'b0;
    end
    if (we_i && off_i == OFF_PRESET) begin
      preset_d = be_merge(preset_q, wdata_i, byteen_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    case (off_i)
      OFF_CTRL:   rdata_o = {28'd0, ctrl_q};
      OFF_PRESET: rdata_o = preset_q;
      OFF_COUNT:  rdata_o = count_q;
      default:    rdata_o = 32'd0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-side bus responder: word RAM plus timer; DM_FAULT_CHECK_EN enables access-fault checking
module dm_responder
  import dm_pkg::*;
#(
  parameter int          RAM_WORDS  = 3072,
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        fault
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]   ram_q [RAM_WORDS];
  logic [AW-1:0] word;
  logic          ram_hit, tmr_hit, we, drop, ram_we, tmr_we;
  logic [31:0]   tmr_rdata;
  logic          unused_addr;

  assign unused_addr = ^addr[1:0];
  assign word    = addr[AW+1:2];
  assign ram_hit = (addr < RAM_BYTES);
  assign tmr_hit = (addr[31:4] == TIMER_BASE[31:4]) && (addr[3:2] != 2'd3);
  assign we      = |byteen;

`ifdef DM_FAULT_CHECK_EN
  logic fault_q;
  assign drop = we && ((!ram_hit && !tmr_hit) ||
                       (tmr_hit && byteen != 4'b1111) ||
                       !be_legal(byteen));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_q | drop;
  end
  assign fault = fault_q;
`else
  assign drop  = 1'b0;
  assign fault = 1'b0;
`endif

  assign ram_we = we && ram_hit && !drop;
  assign tmr_we = we && tmr_hit && !drop;

  // Clearing the whole array on reset is only meaningful for the behavioural RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byteen[b]) ram_q[word][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  dm_timer u_timer (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (tmr_we),
    .off_i    (addr[3:2]),
    .wdata_i  (wdata),
    .byteen_i (byteen),
    .rdata_o  (tmr_rdata),
    .irq_o    (irq)
  );

  always_comb begin
    if (ram_hit)      rdata = ram_q[word];
    else if (tmr_hit) rdata = tmr_rdata;
    else              rdata = 32'd0;
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench for dm_responder (RAM, timer modes, reset, DM_FAULT_CHECK_EN)
module tb_dm_responder;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

`ifdef DM_FAULT_CHECK_EN
  localparam bit FLT = 1'b1;
`else
  localparam bit FLT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  byteen;
  logic        irq, fault;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] max_cnt;

  always #5 clk = ~clk;

  dm_responder dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .byteen (byteen),
    .rdata  (rdata),
    .irq    (irq),
    .fault  (fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byteen = be;
    tick(1);
    byteen = 4'b0000;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; addr = '0; wdata = '0; byteen = '0;
    tick(3);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rd("rst_ctrl", A_CTRL, 32'd0);
    rst = 1'b1;
    tick(1);

    wr(32'h10, 32'hDEADBEEF, 4'b1111);
    rd("ram_full", 32'h10, 32'hDEADBEEF);
    wr(32'h10, 32'h00AA0000, 4'b0100);
    rd("ram_byte2", 32'h10, 32'hDEAABEEF);
    rd("ram_addr_lsb_ignored", 32'h13, 32'hDEAABEEF);
    wr(32'h14, 32'h11223344, 4'b0011);
    rd("ram_half", 32'h14, 32'h00003344);
    wr(32'h2FFC, 32'hCAFEF00D, 4'b1111);
    rd("ram_last", 32'h2FFC, 32'hCAFEF00D);
    rd("ram_past_end", 32'h3000, 32'd0);

    // one-shot, PRESET=3
    wr(A_PRESET, 32'd3, 4'b1111);
    rd("preset_rb", A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(2);
    rd("os_cnt3", A_COUNT, 32'd3);
    tick(1);
    rd("os_cnt2", A_COUNT, 32'd2);
    tick(1);
    rd("os_cnt1", A_COUNT, 32'd1);
    chk("os_irq_pre", {31'd0, irq}, 32'd0);
    tick(1);
    rd("os_cnt0", A_COUNT, 32'd0);
    chk("os_irq_rise", {31'd0, irq}, 32'd1);
    tick(1);
    rd("os_en_cleared", A_CTRL, 32'h8);
    tick(3);
    chk("os_irq_held", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'h0, 4'b1111);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // auto-reload, PRESET=2: IDLE LOAD CNT CNT INT
    wr(A_PRESET, 32'd2, 4'b1111);
    wr(A_CTRL, 32'hB, 4'b1111);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk($sformatf("ar_irq_k%0d", k), {31'd0, irq}, {31'd0, (k % 5) == 4});
      rd($sformatf("ar_cnt_k%0d", k), A_COUNT,
         ((k % 5) == 2) ? 32'd2 : ((k % 5) == 3) ? 32'd1 : 32'd0);
    end
    wr(A_CTRL, 32'h3, 4'b1111);
    max_cnt = '0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk($sformatf("ar_masked_irq%0d", k), {31'd0, irq}, 32'd0);
      addr = A_COUNT;
      #1;
      if (rdata > max_cnt) max_cnt = rdata;
    end
    chk("ar_masked_cycles", max_cnt, 32'd2);
    wr(A_CTRL, 32'h0, 4'b1111);
    tick(3);

    // mid-count disable
    wr(A_PRESET, 32'd10, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(4);
    wr(A_CTRL, 32'h8, 4'b1111);
    rd("md_cnt", A_COUNT, 32'd7);
    tick(3);
    rd("md_frozen", A_COUNT, 32'd7);
    rd("md_ctrl", A_CTRL, 32'h8);
    chk("md_irq", {31'd0, irq}, 32'd0);

    // PRESET=0 acts like 1
    wr(A_PRESET, 32'd0, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(2);
    chk("p0_irq_pre", {31'd0, irq}, 32'd0);
    tick(1);
    chk("p0_irq", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'h0, 4'b1111);

    // async reset during CNT
    wr(A_PRESET, 32'd5, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(4);
    rd("ar_pre_cnt", A_COUNT, 32'd3);
    rst = 1'b0;
    #1;
    chk("areset_irq", {31'd0, irq}, 32'd0);
    rd("areset_ctrl", A_CTRL, 32'd0);
    rd("areset_preset", A_PRESET, 32'd0);
    rd("areset_count", A_COUNT, 32'd0);
    rd("areset_ram", 32'h10, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);

    // COUNT is read-only
    wr(A_COUNT, 32'hFFFFFFFF, 4'b1111);
    rd("count_ro", A_COUNT, 32'd0);
    chk("fault_pre", {31'd0, fault}, 32'd0);

    wr(32'h9000, 32'h12345678, 4'b1111);
    chk("fault_unmapped", {31'd0, fault}, {31'd0, FLT});
    rd("unmapped_rd", 32'h9000, 32'd0);
    wr(A_PRESET, 32'h0000AB00, 4'b0010);
    rd("preset_partial", A_PRESET, FLT ? 32'd0 : 32'h0000AB00);
    wr(32'h20, 32'h11223344, 4'b0101);
    rd("ram_odd_be", 32'h20, FLT ? 32'd0 : 32'h00220044);
    rd("tmr_off12", 32'h7F0C, 32'd0);
    chk("fault_sticky", {31'd0, fault}, {31'd0, FLT});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
